// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: arms on entry into TRIGGER_LINE and grants clients in index order.
// Optional hung-client watchdog is built when SCHED_WATCHDOG_EN is defined.
module frame_update_scheduler #(
    parameter int NUM_CLIENTS    = 3,
    parameter int TRIGGER_LINE   = 480,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [9:0]             pixelY,
    input  logic [NUM_CLIENTS-1:0] skipMask,
    input  logic [NUM_CLIENTS-1:0] done,
    input  logic                   clearFlags,
    output logic [NUM_CLIENTS-1:0] start,
    output logic                   frameStart,
    output logic                   frameDone,
    output logic                   busy,
    output logic                   overrun,
    output logic [NUM_CLIENTS-1:0] timeoutFlags,
    output logic [15:0]            frameCount
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        RUN   = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } schedState;

    schedState              state;
    logic [9:0]             prevY;
    logic [IW-1:0]          idx;
    logic [NUM_CLIENTS-1:0] skipLatched;

    logic                   trigger;
    logic                   granted;
    logic                   doneIdx;
    logic                   wdFire;
    logic                   releaseNow;
    logic [IW:0]            firstPick;
    logic [IW:0]            nextPick;

`ifdef SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] waitCnt;
`endif

    // {found, index} of the lowest non-skipped client at or above 'from'
    function automatic logic [IW:0] pickFrom(input logic [NUM_CLIENTS-1:0] skip, input int from);
        logic [IW:0] res;
        res = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (!skip[i] && (i >= from)) begin
                res = {1'b1, IW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] oneHot(input logic [IW-1:0] sel);
        logic [NUM_CLIENTS-1:0] res;
        res      = '0;
        res[sel] = 1'b1;
        return res;
    endfunction

    // Trigger detect, client selection and release decision
    always_comb begin
        trigger   = (pixelY == 10'(TRIGGER_LINE)) && (prevY != 10'(TRIGGER_LINE));
        firstPick = pickFrom(skipMask, 0);
        nextPick  = pickFrom(skipLatched, int'(idx) + 1);
        granted   = (start != '0);
        doneIdx   = granted && done[idx];
`ifdef SCHED_WATCHDOG_EN
        wdFire    = granted && !done[idx] && (waitCnt == CW'(TIMEOUT_CYCLES - 1));
`else
        wdFire    = 1'b0;
`endif
        releaseNow = doneIdx || wdFire;
    end

`ifdef SCHED_WATCHDOG_EN
    // Cycles the current grant has been held; restarts on every new grant
    always_ff @(posedge clock) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (!granted || releaseNow) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + CW'(1);
        end
    end
`endif

    // Sequencer FSM with registered outputs and sticky flags
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ARMED;
            prevY        <= 10'd0;
            idx          <= '0;
            skipLatched  <= '0;
            start        <= '0;
            frameStart   <= 1'b0;
            frameDone    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeoutFlags <= '0;
            frameCount   <= 16'd0;
        end else begin
            prevY      <= pixelY;
            frameStart <= 1'b0;
            frameDone  <= 1'b0;
            // A set event in the same cycle as clearFlags wins
            overrun      <= (overrun & ~clearFlags) | (trigger && enable && (state != ARMED));
            timeoutFlags <= (timeoutFlags & ~{NUM_CLIENTS{clearFlags}}) | (wdFire ? oneHot(idx) : '0);
            case (state)
                ARMED: begin
                    if (trigger && enable) begin
                        frameStart  <= 1'b1;
                        busy        <= 1'b1;
                        frameCount  <= frameCount + 16'd1;
                        skipLatched <= skipMask;
                        if (firstPick[IW]) begin
                            idx   <= firstPick[IW-1:0];
                            state <= RUN;
                        end else begin
                            state <= FIN;
                        end
                    end else begin
                        state <= ARMED;
                    end
                end
                RUN: begin
                    if (!granted) begin
                        start <= oneHot(idx);
                    end else if (releaseNow) begin
                        start <= '0;
                        state <= nextPick[IW] ? GAP : FIN;
                    end else begin
                        start <= start;
                    end
                end
                GAP: begin
                    // Loading start here keeps the handoff at two cycles after done
                    idx   <= nextPick[IW-1:0];
                    start <= oneHot(nextPick[IW-1:0]);
                    state <= RUN;
                end
                FIN: begin
                    frameDone <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ARMED;
                end
                default: begin
                    start <= '0;
                    busy  <= 1'b0;
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule
